execute_pipe_reg: RTL and testbench
===================================

// Module: execute_pipe_reg
// PURPOSE
//  Decode->Execute pipeline register of the Y86-64 pipelined core, with the 15-entry register file folded in.
//  Registers file operands valA/valB from rA/rB/icode and captures all decode-stage fields into E-stage outputs on each rising clock edge.
//  Write-back stage writes the register file through two write ports.
//  Supports stall (hold) and bubble (insert NOP) from the hazard-control unit.
// PARAMETERS
//  W        64   data width of valC/valP/valA/valB and register-file entries
//  NREG     15   architectural registers %rax..%r14 (id 4'hF = RNONE)
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous active-low reset
//  e_stall   in   1   1: hold all E outputs this edge
//  e_bubble  in   1   1: load NOP bubble this edge (wins over e_stall)
//  d_status  in   4   stat code: 1 AOK, 2 HLT, 3 ADR, 4 INS
//  d_icode   in   4   instruction code
//  d_ifun    in   4   function code
//  d_rA      in   4   register A specifier (F = none)
//  d_rB      in   4   register B specifier (F = none)
//  d_valC    in   W   constant word
//  d_valP    in   W   incremented PC
//  w_dstE    in   4   write-port E reg id (F = no write)
//  w_valE    in   W   write-port E data
//  w_dstM    in   4   write-port M reg id (F = no write)
//  w_valM    in   W   write-port M data
//  e_status, e_icode, e_ifun, e_rA, e_rB   out 4   registered copies of d_*
//  e_valC, e_valP                          out W   registered copies of d_*
//  e_valA, e_valB                          out W   registered operand values
//  e_srcA, e_srcB                          out 4   registered source reg ids (for hazard unit)
// BEHAVIOUR
//  - Reset (rst_n=0, async): status=1 AOK, icode=1 NOP, ifun=0, rA=rB=srcA=srcB=F, valC=valP=valA=valB=0; all 15 regs=0.
//  - Latency 1 edge: values present on d_* before rising edge appear on e_* after it; outputs stable between edges.
//  - srcA: rA for icode 2,4,6,A (rrmovq/cmov, rmmovq, OPq, pushq); 4 (%rsp) for B,9 (popq, ret); else F.
//  - srcB: rB for icode 3? no - rB for 4,5,6 (rmmovq, mrmovq, OPq); 4 for A,B,8,9 (push, pop, call, ret); else F.
//  - valA: d_valP if icode 7 or 8 (jXX, call); else regfile[srcA]; 0 if srcA=F.  valB: regfile[srcB]; 0 if srcB=F.
//  - Register file: two writes per edge at rising clk; id F ignored; if w_dstE==w_dstM!=F, M wins.
//  - Same-edge write/read: if srcA/srcB equals an active w_dst, captured value is the write data (write-through bypass, M over E).
//  - e_bubble=1: load status=1, icode=1, ifun=0, ids F, values 0 (register-file writes still occur).
//  - e_stall=1 and e_bubble=0: all E outputs hold; register-file writes still occur.
//  - Unknown icodes pass through unchanged with srcA=srcB=F, valA=valB=0; no status rewriting here.
// STRUCTURE
//  - Shared package y86_pkg: icode constants (HALT 0..POPQ B), stat codes, RNONE=4'hF, RRSP=4'h4, W.
//  - One sub-module: y86_regfile (15xW, 2 comb read ports, 2 write ports, async reset, write-through bypass).
//  - execute_pipe_reg = src-select logic + regfile instance + E pipeline flops.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> immediately e_icode=1, e_status=1, e_rA=F, e_valA=0, no clk edge needed.
//  2 OPq capture: icode=6 ifun=0 rA=6 rB=6 valC=100 valP=64, regs 0 -> after edge e_icode=6, e_rA=e_rB=6,
//    e_valC=100, e_valP=64, e_valA=0, e_valB=0; stable over further edges with constant inputs.
//  3 Writeback then read: w_dstE=3 w_valE=55 one edge; then icode=6 rA=3 rB=F -> e_valA=55, e_valB=0.
//  4 Bypass + priority: w_dstE=w_dstM=2 (valE=7, valM=9) same edge as icode=6 rA=2 -> e_valA=9; regfile[2]=9.
//  5 call/push/pop: regfile[4]=200; icode=8 valP=0x40 -> e_valA=0x40 e_valB=200; icode=B -> e_valA=e_valB=200.
//  6 Stall/bubble: e_stall=1 with new inputs -> outputs hold; e_stall=e_bubble=1 -> e_icode=1, e_valA=0, e_status=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction/status codes, register ids and
// the decode-stage source-register selection rules.
package y86_pkg;

    localparam int W    = 64;
    localparam int NREG = 15;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        S_AOK = 4'h1,
        S_HLT = 4'h2,
        S_ADR = 4'h3,
        S_INS = 4'h4
    } stat_e;

    // Narrow E-stage fields, bundled so bubble/reset values live in one place
    typedef struct packed {
        logic [3:0] status;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] rA;
        logic [3:0] rB;
        logic [3:0] srcA;
        logic [3:0] srcB;
    } e_ctl_t;

    localparam e_ctl_t E_CTL_NOP = '{
        status: S_AOK,
        icode:  I_NOP,
        ifun:   4'h0,
        rA:     RNONE,
        rB:     RNONE,
        srcA:   RNONE,
        srcB:   RNONE
    };

    // Register read by operand A: the named rA, or the stack pointer for pop/ret
    function automatic logic [3:0] src_a_sel(input logic [3:0] icode, input logic [3:0] ra);
        logic [3:0] s;
        s = RNONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: s = ra;
            I_POPQ, I_RET:                      s = RRSP;
            default:                            s = RNONE;
        endcase
        return s;
    endfunction

    // Register read by operand B: the named rB, or the stack pointer for stack ops
    function automatic logic [3:0] src_b_sel(input logic [3:0] icode, input logic [3:0] rb);
        logic [3:0] s;
        s = RNONE;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:         s = rb;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:    s = RRSP;
            default:                           s = RNONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15-entry register file: two combinational read ports, two write ports
// (M has priority over E on the same id), and write-through so a read in
// the same cycle as a write sees the new data.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int W    = y86_pkg::W,
    parameter int NREG = y86_pkg::NREG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   i_raddrA,
    input  logic [3:0]   i_raddrB,
    output logic [W-1:0] o_rdataA,
    output logic [W-1:0] o_rdataB,
    input  logic [3:0]   i_wdstE,
    input  logic [W-1:0] i_wvalE,
    input  logic [3:0]   i_wdstM,
    input  logic [W-1:0] i_wvalM
);

    logic [NREG-1:0][W-1:0] r_regs;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [3:0] ID = 4'(gi);
            // Per-register write; port M is checked first so it wins a same-id collision
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_regs[gi] <= '0;
                else if (i_wdstM == ID)
                    r_regs[gi] <= i_wvalM;
                else if (i_wdstE == ID)
                    r_regs[gi] <= i_wvalE;
            end
        end
    endgenerate

    // Read with bypass: pending M write, then pending E write, then stored value
    function automatic logic [W-1:0] rd(input logic [3:0] addr,
                                        input logic [NREG-1:0][W-1:0] regs,
                                        input logic [3:0] dm, input logic [W-1:0] vm,
                                        input logic [3:0] de, input logic [W-1:0] ve);
        logic [W-1:0] v;
        v = '0;
        if (addr != RNONE) begin
            if (dm == addr)
                v = vm;
            else if (de == addr)
                v = ve;
            else
                for (int i = 0; i < NREG; i++)
                    if (addr == 4'(i)) v = regs[i];
        end
        return v;
    endfunction

    // Both read ports share the same bypass rule
    always_comb begin
        o_rdataA = rd(i_raddrA, r_regs, i_wdstM, i_wvalM, i_wdstE, i_wvalE);
        o_rdataB = rd(i_raddrB, r_regs, i_wdstM, i_wvalM, i_wdstE, i_wvalE);
    end

endmodule

// File: rtl/execute_pipe_reg.sv
// Decode->Execute pipeline register with the register file folded in.
// Picks source registers from the decoded instruction, reads operands
// (with write-back bypass) and captures everything into the E stage,
// honouring stall (hold) and bubble (NOP insert, higher priority).
module execute_pipe_reg
    import y86_pkg::*;
#(
    parameter int W    = y86_pkg::W,
    parameter int NREG = y86_pkg::NREG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e_stall,
    input  logic         e_bubble,
    input  logic [3:0]   d_status,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [3:0]   d_rA,
    input  logic [3:0]   d_rB,
    input  logic [W-1:0] d_valC,
    input  logic [W-1:0] d_valP,
    input  logic [3:0]   w_dstE,
    input  logic [W-1:0] w_valE,
    input  logic [3:0]   w_dstM,
    input  logic [W-1:0] w_valM,
    output logic [3:0]   e_status,
    output logic [3:0]   e_icode,
    output logic [3:0]   e_ifun,
    output logic [3:0]   e_rA,
    output logic [3:0]   e_rB,
    output logic [W-1:0] e_valC,
    output logic [W-1:0] e_valP,
    output logic [W-1:0] e_valA,
    output logic [W-1:0] e_valB,
    output logic [3:0]   e_srcA,
    output logic [3:0]   e_srcB
);

    logic [3:0]   w_srcA, w_srcB;
    logic [W-1:0] w_rdA, w_rdB, w_valA;
    e_ctl_t       w_ctl_d, r_ctl;

    assign w_srcA = src_a_sel(d_icode, d_rA);
    assign w_srcB = src_b_sel(d_icode, d_rB);

    y86_regfile #(.W(W), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddrA (w_srcA),
        .i_raddrB (w_srcB),
        .o_rdataA (w_rdA),
        .o_rdataB (w_rdB),
        .i_wdstE  (w_dstE),
        .i_wvalE  (w_valE),
        .i_wdstM  (w_dstM),
        .i_wvalM  (w_valM)
    );

    // jXX/call carry the return/fall-through PC in valA instead of a register
    assign w_valA = (d_icode == I_JXX || d_icode == I_CALL) ? d_valP : w_rdA;

    assign w_ctl_d = '{
        status: d_status,
        icode:  d_icode,
        ifun:   d_ifun,
        rA:     d_rA,
        rB:     d_rB,
        srcA:   w_srcA,
        srcB:   w_srcB
    };

    // E-stage capture: bubble beats stall, stall holds, otherwise load decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl  <= E_CTL_NOP;
            e_valC <= '0;
            e_valP <= '0;
            e_valA <= '0;
            e_valB <= '0;
        end else if (e_bubble) begin
            r_ctl  <= E_CTL_NOP;
            e_valC <= '0;
            e_valP <= '0;
            e_valA <= '0;
            e_valB <= '0;
        end else if (!e_stall) begin
            r_ctl  <= w_ctl_d;
            e_valC <= d_valC;
            e_valP <= d_valP;
            e_valA <= w_valA;
            e_valB <= w_rdB;
        end
    end

    assign e_status = r_ctl.status;
    assign e_icode  = r_ctl.icode;
    assign e_ifun   = r_ctl.ifun;
    assign e_rA     = r_ctl.rA;
    assign e_rB     = r_ctl.rB;
    assign e_srcA   = r_ctl.srcA;
    assign e_srcB   = r_ctl.srcB;

endmodule

// File: tb/tb_execute_pipe_reg.sv
// Bench for execute_pipe_reg: directed vectors, a behavioural model of the
// architectural state checked every cycle, plus literal spot checks.
module tb_execute_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e_stall, e_bubble;
    logic [3:0]  d_status, d_icode, d_ifun, d_rA, d_rB;
    logic [63:0] d_valC, d_valP;
    logic [3:0]  w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  e_status, e_icode, e_ifun, e_rA, e_rB, e_srcA, e_srcB;
    logic [63:0] e_valC, e_valP, e_valA, e_valB;

    always #5 clk = ~clk;

    execute_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .e_stall(e_stall), .e_bubble(e_bubble),
        .d_status(d_status), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP),
        .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
        .e_status(e_status), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_rA(e_rA), .e_rB(e_rB), .e_valC(e_valC), .e_valP(e_valP),
        .e_valA(e_valA), .e_valB(e_valB), .e_srcA(e_srcA), .e_srcB(e_srcB)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 0;

    // ---------------- behavioural model ----------------
    logic [63:0] m_regs [16];
    logic [3:0]  x_status, x_icode, x_ifun, x_rA, x_rB, x_srcA, x_srcB;
    logic [63:0] x_valC, x_valP, x_valA, x_valB;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
        x_status = 4'h1; x_icode = 4'h1; x_ifun = 4'h0;
        x_rA = 4'hF; x_rB = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
        x_valC = 0; x_valP = 0; x_valA = 0; x_valB = 0;
    endtask

    // One rising edge: write-back commits first (E then M so M wins), then the
    // decode reads see the updated file -- that is what write-through means.
    task automatic model_edge();
        logic [3:0] sa, sb;
        if (w_dstE != 4'hF) m_regs[w_dstE] = w_valE;
        if (w_dstM != 4'hF) m_regs[w_dstM] = w_valM;
        if (e_bubble) begin
            x_status = 4'h1; x_icode = 4'h1; x_ifun = 4'h0;
            x_rA = 4'hF; x_rB = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
            x_valC = 0; x_valP = 0; x_valA = 0; x_valB = 0;
        end else if (!e_stall) begin
            sa = (d_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? d_rA :
                 (d_icode inside {4'hB, 4'h9}) ? 4'h4 : 4'hF;
            sb = (d_icode inside {4'h4, 4'h5, 4'h6}) ? d_rB :
                 (d_icode inside {4'hA, 4'hB, 4'h8, 4'h9}) ? 4'h4 : 4'hF;
            x_status = d_status; x_icode = d_icode; x_ifun = d_ifun;
            x_rA = d_rA; x_rB = d_rB; x_srcA = sa; x_srcB = sb;
            x_valC = d_valC; x_valP = d_valP;
            x_valA = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valP :
                     (sa == 4'hF) ? 64'd0 : m_regs[sa];
            x_valB = (sb == 4'hF) ? 64'd0 : m_regs[sb];
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("status", 64'(e_status), 64'(x_status));
            chk("icode",  64'(e_icode),  64'(x_icode));
            chk("ifun",   64'(e_ifun),   64'(x_ifun));
            chk("rA",     64'(e_rA),     64'(x_rA));
            chk("rB",     64'(e_rB),     64'(x_rB));
            chk("srcA",   64'(e_srcA),   64'(x_srcA));
            chk("srcB",   64'(e_srcB),   64'(x_srcB));
            chk("valC",   e_valC, x_valC);
            chk("valP",   e_valP, x_valP);
            chk("valA",   e_valA, x_valA);
            chk("valB",   e_valB, x_valB);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        d_status = 4'h1; d_icode = ic; d_ifun = 4'h0;
        d_rA = ra; d_rB = rb; d_valC = vc; d_valP = vp;
    endtask

    task automatic set_w(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
    endtask

    initial begin
        rst_n = 1'b0; e_stall = 0; e_bubble = 0;
        set_d(4'h1, 4'hF, 4'hF, 0, 0);
        set_w(4'hF, 0, 4'hF, 0);
        model_reset();
        #7;
        chk("rst_icode",  64'(e_icode),  64'h1);
        chk("rst_status", 64'(e_status), 64'h1);
        chk("rst_rA",     64'(e_rA),     64'hF);
        chk("rst_valA",   e_valA, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_en = 1;

        // OPq capture from an all-zero file, then hold steady
        set_d(4'h6, 4'h6, 4'h6, 64'd100, 64'd64);
        tick();
        chk("opq_icode", 64'(e_icode), 64'h6);
        chk("opq_rA",    64'(e_rA),    64'h6);
        chk("opq_valC",  e_valC, 64'd100);
        chk("opq_valP",  e_valP, 64'd64);
        chk("opq_valA",  e_valA, 64'd0);
        tick();
        tick();
        chk("opq_stable_valC", e_valC, 64'd100);

        // Write-back, then read it next cycle
        set_d(4'h1, 4'hF, 4'hF, 0, 0);
        set_w(4'h3, 64'd55, 4'hF, 0);
        tick();
        set_w(4'hF, 0, 4'hF, 0);
        set_d(4'h6, 4'h3, 4'hF, 0, 0);
        tick();
        chk("wb_valA", e_valA, 64'd55);
        chk("wb_valB", e_valB, 64'd0);

        // Same-edge bypass with M over E, then the file keeps the M value
        set_w(4'h2, 64'd7, 4'h2, 64'd9);
        set_d(4'h6, 4'h2, 4'hF, 0, 0);
        tick();
        chk("byp_valA", e_valA, 64'd9);
        set_w(4'hF, 0, 4'hF, 0);
        set_d(4'h6, 4'hF, 4'h2, 0, 0);
        tick();
        chk("rf2_valB", e_valB, 64'd9);

        // call / popq using %rsp
        set_w(4'hF, 0, 4'h4, 64'd200);
        set_d(4'h1, 4'hF, 4'hF, 0, 0);
        tick();
        set_w(4'hF, 0, 4'hF, 0);
        set_d(4'h8, 4'hF, 4'hF, 64'h1234, 64'h40);
        tick();
        chk("call_valA", e_valA, 64'h40);
        chk("call_valB", e_valB, 64'd200);
        set_d(4'hB, 4'h4, 4'hF, 0, 64'h50);
        tick();
        chk("pop_valA", e_valA, 64'd200);
        chk("pop_valB", e_valB, 64'd200);

        // Stall holds outputs but the write still lands
        e_stall = 1;
        set_w(4'h5, 64'd77, 4'hF, 0);
        set_d(4'h6, 4'h3, 4'h3, 64'd1, 64'd2);
        tick();
        chk("stall_icode", 64'(e_icode), 64'hB);
        chk("stall_valP",  e_valP, 64'h50);
        set_w(4'hF, 0, 4'hF, 0);
        e_bubble = 1;
        tick();
        chk("bub_icode",  64'(e_icode),  64'h1);
        chk("bub_valA",   e_valA, 64'd0);
        chk("bub_status", 64'(e_status), 64'h1);
        e_stall = 0; e_bubble = 0;
        set_d(4'h6, 4'h5, 4'hF, 0, 0);
        tick();
        chk("stallwr_valA", e_valA, 64'd77);

        // Unknown icode passes through, status untouched, no operands
        set_d(4'hC, 4'h3, 4'h5, 64'd9, 64'd10);
        d_status = 4'h4;
        tick();
        chk("unk_icode",  64'(e_icode),  64'hC);
        chk("unk_status", 64'(e_status), 64'h4);
        chk("unk_valA",   e_valA, 64'd0);
        chk("unk_srcB",   64'(e_srcB), 64'hF);

        // Asynchronous reset mid-cycle clears outputs and the file
        #3;
        chk_en = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_icode",  64'(e_icode),  64'h1);
        chk("arst_status", 64'(e_status), 64'h1);
        chk("arst_rA",     64'(e_rA),     64'hF);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_en = 1;
        set_d(4'h6, 4'h5, 4'h3, 0, 0);
        tick();
        chk("arst_rf_valA", e_valA, 64'd0);
        chk("arst_rf_valB", e_valB, 64'd0);
        tick();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
